// File: rtl/pll_clkgen_if.sv
// pll_clkgen_if
//   Groups the power-down/feedback controls and the generated clocks of
//   pll_clkgen. CLKIN1 and RST_N are plain ports of the block, not members here.
//   Members:
//     PWRDWN      user -> pll  synchronous power-down, active-high
//     CLKFBIN     user -> pll  feedback input, accepted and ignored
//     CLKFBOUT/B  pll -> user  feedback clock and its complement
//     CLKOUT0..6  pll -> user  divided clocks
//     CLKOUT0B..3B pll -> user complements of CLKOUT0..3
//     LOCKED      pll -> user  high while the outputs are running
interface pll_clkgen_if;
    logic PWRDWN;
    logic CLKFBIN;
    logic CLKFBOUT;
    logic CLKFBOUTB;
    logic CLKOUT0;
    logic CLKOUT1;
    logic CLKOUT2;
    logic CLKOUT3;
    logic CLKOUT4;
    logic CLKOUT5;
    logic CLKOUT6;
    logic CLKOUT0B;
    logic CLKOUT1B;
    logic CLKOUT2B;
    logic CLKOUT3B;
    logic LOCKED;

    modport master (
        output PWRDWN, CLKFBIN,
        input  CLKFBOUT, CLKFBOUTB,
        input  CLKOUT0, CLKOUT1, CLKOUT2, CLKOUT3, CLKOUT4, CLKOUT5, CLKOUT6,
        input  CLKOUT0B, CLKOUT1B, CLKOUT2B, CLKOUT3B,
        input  LOCKED
    );

    modport slave (
        input  PWRDWN, CLKFBIN,
        output CLKFBOUT, CLKFBOUTB,
        output CLKOUT0, CLKOUT1, CLKOUT2, CLKOUT3, CLKOUT4, CLKOUT5, CLKOUT6,
        output CLKOUT0B, CLKOUT1B, CLKOUT2B, CLKOUT3B,
        output LOCKED
    );
endinterface

// File: rtl/pll_clkgen.sv
// pll_clkgen
//   Cycle-accurate PLL/MMCM output stage running on the VCO-rate clock.
//   Eight integer dividers (CLKOUT0..6 and the feedback divider) produce
//   registered clocks with elaboration-time duty cycle and phase. LOCKED rises
//   LOCK_CYCLES edges after reset/power-down is released; the dividers start
//   on that same edge so every zero-phase output rises together.
//   Ports:
//     CLKIN1  VCO-rate clock, all logic on its rising edge
//     RST_N   synchronous reset, active-low
//     bus     pll_clkgen_if slave: PWRDWN/CLKFBIN in, clocks and LOCKED out
module pll_clkgen #(
    parameter int    CLKFBOUT_MULT      = 4,
    parameter real   CLKFBOUT_PHASE     = 0.0,
    parameter int    CLKOUT0_DIVIDE     = 2,
    parameter int    CLKOUT1_DIVIDE     = 2,
    parameter int    CLKOUT2_DIVIDE     = 2,
    parameter int    CLKOUT3_DIVIDE     = 2,
    parameter int    CLKOUT4_DIVIDE     = 2,
    parameter int    CLKOUT5_DIVIDE     = 2,
    parameter int    CLKOUT6_DIVIDE     = 2,
    parameter real   CLKOUT0_DUTY_CYCLE = 0.5,
    parameter real   CLKOUT1_DUTY_CYCLE = 0.5,
    parameter real   CLKOUT2_DUTY_CYCLE = 0.5,
    parameter real   CLKOUT3_DUTY_CYCLE = 0.5,
    parameter real   CLKOUT4_DUTY_CYCLE = 0.5,
    parameter real   CLKOUT5_DUTY_CYCLE = 0.5,
    parameter real   CLKOUT6_DUTY_CYCLE = 0.5,
    parameter real   CLKOUT0_PHASE      = 0.0,
    parameter real   CLKOUT1_PHASE      = 0.0,
    parameter real   CLKOUT2_PHASE      = 0.0,
    parameter real   CLKOUT3_PHASE      = 0.0,
    parameter real   CLKOUT4_PHASE      = 0.0,
    parameter real   CLKOUT5_PHASE      = 0.0,
    parameter real   CLKOUT6_PHASE      = 0.0,
    parameter string CLKOUT4_CASCADE    = "FALSE",
    parameter int    LOCK_CYCLES        = 64
) (
    input  logic         CLKIN1,
    input  logic         RST_N,
    pll_clkgen_if.slave  bus
);

    localparam bit CASCADE = (CLKOUT4_CASCADE == "TRUE");
    localparam int LW      = $clog2(LOCK_CYCLES + 1);

    // Channel index 0..6 are CLKOUT0..6, index 7 is the feedback divider.
    function automatic int div_of(input int n);
        case (n)
            0:       return CLKOUT0_DIVIDE;
            1:       return CLKOUT1_DIVIDE;
            2:       return CLKOUT2_DIVIDE;
            3:       return CLKOUT3_DIVIDE;
            4:       return CLKOUT4_DIVIDE;
            5:       return CLKOUT5_DIVIDE;
            6:       return CLKOUT6_DIVIDE;
            default: return CLKFBOUT_MULT;
        endcase
    endfunction

    function automatic real duty_of(input int n);
        case (n)
            0:       return CLKOUT0_DUTY_CYCLE;
            1:       return CLKOUT1_DUTY_CYCLE;
            2:       return CLKOUT2_DUTY_CYCLE;
            3:       return CLKOUT3_DUTY_CYCLE;
            4:       return CLKOUT4_DUTY_CYCLE;
            5:       return CLKOUT5_DUTY_CYCLE;
            6:       return CLKOUT6_DUTY_CYCLE;
            default: return 0.5;
        endcase
    endfunction

    function automatic real phase_of(input int n);
        case (n)
            0:       return CLKOUT0_PHASE;
            1:       return CLKOUT1_PHASE;
            2:       return CLKOUT2_PHASE;
            3:       return CLKOUT3_PHASE;
            4:       return CLKOUT4_PHASE;
            5:       return CLKOUT5_PHASE;
            6:       return CLKOUT6_PHASE;
            default: return CLKFBOUT_PHASE;
        endcase
    endfunction

    // High count: nearest integer to duty*D, saturated so the clock toggles.
    function automatic int high_count(input int d, input real duty);
        int h;
        h = $rtoi(duty * $itor(d) + 0.5);
        if (h < 1)     h = 1;
        if (h > d - 1) h = d - 1;
        return h;
    endfunction

    // Phase offset in whole VCO cycles, rounded to nearest.
    function automatic int phase_offset(input int d, input real phase);
        return $rtoi(phase * $itor(d) / 360.0 + 0.5) % d;
    endfunction

    logic          halt;
    logic          start;
    logic          locked;
    logic [LW-1:0] lock_cnt;
    logic          rise6;
    logic          unused_fbin;

    assign unused_fbin = bus.CLKFBIN;
    assign halt        = !RST_N || bus.PWRDWN;
    assign start       = !halt && !locked && (lock_cnt == LW'(LOCK_CYCLES - 1));

    always_ff @(posedge CLKIN1) begin
        if (halt) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!locked) begin
            lock_cnt <= lock_cnt + LW'(1);
            if (lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                locked <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_ch
        localparam int D        = div_of(g);
        localparam int H        = high_count(D, duty_of(g));
        localparam int P        = phase_offset(D, phase_of(g));
        localparam int I        = (D - P) % D;
        localparam bit INIT_OUT = (I < H);
        // In cascade mode CLKOUT4 counts CLKOUT6 rising edges, not VCO edges.
        localparam bit GATED    = (g == 4) && CASCADE;

        logic [7:0] cnt;
        logic [7:0] cnt_nxt;
        logic       step;
        logic       out_q;
        logic       out_nxt;

        assign step = locked && (!GATED || rise6);

        always_comb begin
            cnt_nxt = cnt;
            if (step) begin
                cnt_nxt = (cnt == 8'(D - 1)) ? 8'd0 : cnt + 8'd1;
            end
            out_nxt = (cnt_nxt < 8'(H));
        end

        // Counters are only held during halt; they reload on the start edge.
        always_ff @(posedge CLKIN1) begin
            if (halt) begin
                out_q <= 1'b0;
            end else if (start) begin
                cnt   <= 8'(I);
                out_q <= INIT_OUT;
            end else if (locked) begin
                cnt   <= cnt_nxt;
                out_q <= out_nxt;
            end
        end

        if (g < 4 || g == 7) begin : g_b
            logic outb_q;
            // Complement is registered alongside the clock and is 0 while unlocked.
            always_ff @(posedge CLKIN1) begin
                if (halt) begin
                    outb_q <= 1'b0;
                end else if (start) begin
                    outb_q <= !INIT_OUT;
                end else if (locked) begin
                    outb_q <= !out_nxt;
                end
            end
        end
    end

    // Registered CLKOUT6 is about to go 0->1 on this edge.
    assign rise6 = g_ch[6].out_nxt && !g_ch[6].out_q;

    assign bus.CLKOUT0   = g_ch[0].out_q;
    assign bus.CLKOUT1   = g_ch[1].out_q;
    assign bus.CLKOUT2   = g_ch[2].out_q;
    assign bus.CLKOUT3   = g_ch[3].out_q;
    assign bus.CLKOUT4   = g_ch[4].out_q;
    assign bus.CLKOUT5   = g_ch[5].out_q;
    assign bus.CLKOUT6   = g_ch[6].out_q;
    assign bus.CLKFBOUT  = g_ch[7].out_q;
    assign bus.CLKOUT0B  = g_ch[0].g_b.outb_q;
    assign bus.CLKOUT1B  = g_ch[1].g_b.outb_q;
    assign bus.CLKOUT2B  = g_ch[2].g_b.outb_q;
    assign bus.CLKOUT3B  = g_ch[3].g_b.outb_q;
    assign bus.CLKFBOUTB = g_ch[7].g_b.outb_q;
    assign bus.LOCKED    = locked;

endmodule

// File: tb/tb_pll_clkgen.sv
// tb_pll_clkgen
//   Two pll_clkgen instances driven by the same clock, reset, power-down and
//   random CLKFBIN. Instance a: defaults plus divide-5/40% duty, 90 degree
//   phase, CLKOUT4 cascaded on CLKOUT6. Instance b: short lock, odd dividers,
//   clamped duty cycles and non-zero feedback phase. A period/phase model
//   predicts every output on every cycle; literal waveforms pin the model.
module tb_pll_clkgen;

    logic clk = 1'b0;
    logic rst_n;
    logic pwrdwn;
    logic fbin;

    always #5 clk = ~clk;

    pll_clkgen_if bus_a ();
    pll_clkgen_if bus_b ();

    assign bus_a.PWRDWN  = pwrdwn;
    assign bus_b.PWRDWN  = pwrdwn;
    assign bus_a.CLKFBIN = fbin;
    assign bus_b.CLKFBIN = ~fbin;

    pll_clkgen #(
        .CLKOUT1_DIVIDE(5), .CLKOUT1_DUTY_CYCLE(0.4),
        .CLKOUT2_DIVIDE(8), .CLKOUT2_PHASE(90.0),
        .CLKOUT3_DIVIDE(8),
        .CLKOUT4_DIVIDE(3), .CLKOUT4_CASCADE("TRUE"),
        .CLKOUT5_DIVIDE(7), .CLKOUT5_DUTY_CYCLE(0.3), .CLKOUT5_PHASE(100.0),
        .CLKOUT6_DIVIDE(4)
    ) u_a (
        .CLKIN1(clk), .RST_N(rst_n), .bus(bus_a)
    );

    pll_clkgen #(
        .CLKFBOUT_MULT(3), .CLKFBOUT_PHASE(120.0),
        .CLKOUT0_DIVIDE(2), .CLKOUT0_PHASE(270.0),
        .CLKOUT1_DIVIDE(128), .CLKOUT1_DUTY_CYCLE(0.01),
        .CLKOUT2_DIVIDE(3), .CLKOUT2_DUTY_CYCLE(0.9),
        .CLKOUT3_DIVIDE(2), .CLKOUT3_DUTY_CYCLE(0.1),
        .CLKOUT4_DIVIDE(6), .CLKOUT4_DUTY_CYCLE(0.75), .CLKOUT4_PHASE(180.0),
        .CLKOUT5_DIVIDE(7), .CLKOUT5_DUTY_CYCLE(0.3), .CLKOUT5_PHASE(100.0),
        .CLKOUT6_DIVIDE(3),
        .LOCK_CYCLES(3)
    ) u_b (
        .CLKIN1(clk), .RST_N(rst_n), .bus(bus_b)
    );

    logic [7:0] out_a, out_b;
    logic [4:0] outb_a, outb_b;
    assign out_a  = {bus_a.CLKFBOUT, bus_a.CLKOUT6, bus_a.CLKOUT5, bus_a.CLKOUT4,
                     bus_a.CLKOUT3, bus_a.CLKOUT2, bus_a.CLKOUT1, bus_a.CLKOUT0};
    assign out_b  = {bus_b.CLKFBOUT, bus_b.CLKOUT6, bus_b.CLKOUT5, bus_b.CLKOUT4,
                     bus_b.CLKOUT3, bus_b.CLKOUT2, bus_b.CLKOUT1, bus_b.CLKOUT0};
    assign outb_a = {bus_a.CLKFBOUTB, bus_a.CLKOUT3B, bus_a.CLKOUT2B, bus_a.CLKOUT1B, bus_a.CLKOUT0B};
    assign outb_b = {bus_b.CLKFBOUTB, bus_b.CLKOUT3B, bus_b.CLKOUT2B, bus_b.CLKOUT1B, bus_b.CLKOUT0B};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel parameters (index 7 = feedback) for instances a and b.
    int  divs [2][8] = '{'{2, 5, 8, 8, 3, 7, 4, 4}, '{2, 128, 3, 2, 6, 7, 3, 3}};
    real dutys[2][8] = '{'{0.5, 0.4, 0.5, 0.5, 0.5, 0.3, 0.5, 0.5},
                         '{0.5, 0.01, 0.9, 0.1, 0.75, 0.3, 0.5, 0.5}};
    real phs  [2][8] = '{'{0.0, 0.0, 90.0, 0.0, 0.0, 100.0, 0.0, 0.0},
                         '{270.0, 0.0, 0.0, 0.0, 180.0, 100.0, 0.0, 120.0}};
    int  lockc[2]    = '{64, 3};

    int md[2][8], mh[2][8], mi[2][8];

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int c = 0; c < 8; c++) begin
                int d, h, p;
                d = divs[u][c];
                h = $rtoi(dutys[u][c] * $itor(d) + 0.5);
                if (h < 1) h = 1;
                if (h > d - 1) h = d - 1;
                p = $rtoi(phs[u][c] * $itor(d) / 360.0 + 0.5) % d;
                md[u][c] = d;
                mh[u][c] = h;
                mi[u][c] = (d - p) % d;
            end
        end
        check("model_h_a1", 16'(mh[0][1]), 16'd2);
        check("model_i_a2", 16'(mi[0][2]), 16'd6);
        check("model_h_b2", 16'(mh[1][2]), 16'd2);
        check("model_h_b3", 16'(mh[1][3]), 16'd1);
        check("model_h_b4", 16'(mh[1][4]), 16'd5);
        check("model_i_b5", 16'(mi[1][5]), 16'd5);
        check("model_i_bfb", 16'(mi[1][7]), 16'd2);
        check("model_i_b0", 16'(mi[1][0]), 16'd0);
    end

    // Output at k cycles after the lock edge for a free-running divider.
    function automatic bit ch_out(input int u, input int c, input int k);
        return ((k + mi[u][c]) % md[u][c]) < mh[u][c];
    endfunction

    int since[2];
    int kk[2];
    int rr;

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n || pwrdwn) begin
                since[u] = 0;
                kk[u]    = -1;
                if (u == 0) rr = 0;
            end else begin
                since[u]++;
                if (since[u] >= lockc[u]) begin
                    kk[u]++;
                    if (u == 0 && kk[0] > 0 && ch_out(0, 6, kk[0]) && !ch_out(0, 6, kk[0] - 1)) rr++;
                end
            end
        end
        #1;
        for (int u = 0; u < 2; u++) begin
            logic [7:0] eo;
            logic [4:0] eb;
            logic       el;
            el = (kk[u] >= 0);
            for (int c = 0; c < 8; c++) begin
                if (!el)                 eo[c] = 1'b0;
                else if (u == 0 && c == 4) eo[c] = ((mi[0][4] + rr) % md[0][4]) < mh[0][4];
                else                     eo[c] = ch_out(u, c, kk[u]);
            end
            eb = el ? ~{eo[7], eo[3:0]} : 5'd0;
            if (u == 0) begin
                check("cyc_locked_a", 16'(bus_a.LOCKED), 16'(el));
                check("cyc_out_a", 16'(out_a), 16'(eo));
                check("cyc_outb_a", 16'(outb_a), 16'(eb));
            end else begin
                check("cyc_locked_b", 16'(bus_b.LOCKED), 16'(el));
                check("cyc_out_b", 16'(out_b), 16'(eo));
                check("cyc_outb_b", 16'(outb_b), 16'(eb));
            end
        end
    end

    initial begin
        fbin = 1'b0;
        forever begin
            @(negedge clk);
            fbin = 1'($urandom_range(0, 1));
        end
    end

    // After a release at a negedge: lock timing and phase-aligned restart.
    task automatic relock_checks(input string tag);
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #2;
            if (c == 2)  check({tag, "_lock_b_c2"}, 16'(bus_b.LOCKED), 16'd0);
            if (c == 3)  check({tag, "_lock_b_c3"}, 16'(bus_b.LOCKED), 16'd1);
            if (c == 63) check({tag, "_lock_a_c63"}, 16'(bus_a.LOCKED), 16'd0);
            if (c == 63) check({tag, "_out_a_c63"}, 16'(out_a), 16'd0);
            if (c == 64) begin
                check({tag, "_lock_a_c64"}, 16'(bus_a.LOCKED), 16'd1);
                // Zero-phase outputs high, CLKOUT2 (90 deg) and CLKOUT5 low.
                check({tag, "_out_a_c64"}, 16'(out_a), 16'hDB);
            end
        end
    endtask

    task automatic halted_checks(input string tag);
        @(posedge clk);
        #2;
        check({tag, "_lock_a"}, 16'(bus_a.LOCKED), 16'd0);
        check({tag, "_lock_b"}, 16'(bus_b.LOCKED), 16'd0);
        check({tag, "_outs"}, {out_a, out_b}, 16'd0);
        check({tag, "_outbs"}, 16'({outb_a, outb_b}), 16'd0);
    endtask

    logic [15:0] w0, w1, w1b, w2, w3, w4, wfb;

    initial begin
        rst_n  = 1'b0;
        pwrdwn = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        relock_checks("init");
        for (int k = 0; k < 16; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #2;
            end
            w0[k]  = bus_a.CLKOUT0;
            w1[k]  = bus_a.CLKOUT1;
            w1b[k] = bus_a.CLKOUT1B;
            w2[k]  = bus_a.CLKOUT2;
            w3[k]  = bus_a.CLKOUT3;
            w4[k]  = bus_a.CLKOUT4;
            wfb[k] = bus_a.CLKFBOUT;
        end
        check("wave_clkout0", w0, 16'h5555);
        check("wave_clkfbout", wfb, 16'h3333);
        check("wave_clkout1", w1, 16'h8C63);
        check("wave_clkout1b", w1b, 16'h739C);
        check("wave_clkout2", w2, 16'h3C3C);
        check("wave_clkout3", w3, 16'h0F0F);
        check("wave_clkout4_casc", w4, 16'hF0FF);

        repeat (100) @(negedge clk);
        pwrdwn = 1'b1;
        halted_checks("pwrdwn");
        repeat (3) @(negedge clk);
        pwrdwn = 1'b0;
        relock_checks("pwr_rel");

        repeat ($urandom_range(20, 27)) @(negedge clk);
        rst_n = 1'b0;
        halted_checks("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        relock_checks("rst_rel");

        for (int n = 0; n < 8; n++) begin
            int len;
            repeat ($urandom_range(10, 120)) @(negedge clk);
            len = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) pwrdwn = 1'b1;
            else                           rst_n  = 1'b0;
            repeat (len) @(negedge clk);
            pwrdwn = 1'b0;
            rst_n  = 1'b1;
        end
        repeat (100) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
